hdmi_video_timing_gen: RTL and testbench
========================================

# hdmi_video_timing_gen

Parametrised video timing and framebuffer-address generator for the HDMI output path, running in the pixel clock domain ahead of the TMDS encoders. It generates the horizontal and vertical counters, sync pulses with configurable polarity, and the data-enable signal. It also drives a linear framebuffer read address with line stride and a per-frame base address for double buffering. All pixel-side outputs are delayed by a configurable read latency so they line up with the returned pixel data.

## Interface
- H_PIXEL, 640, active pixels per line
- H_FRONT_PORCH, 16, pixels from end of active to hsync start
- H_SYNC, 96, hsync width in pixels
- H_TOT_PIXEL, 800, total pixels per line
- V_PIXEL, 480, active lines per frame
- V_FRONT_PORCH, 10, lines from end of active to vsync start
- V_SYNC, 2, vsync width in lines
- V_TOT_PIXEL, 525, total lines per frame
- SYNC_POL, 1, sync active level (1 = active-high, 0 = active-low)
- CNT_W, 11, width of the X and Y counters
- ADDR_W, 21, framebuffer address width
- LINE_STRIDE, 640, address increment between lines (must be ≥ H_PIXEL)
- RD_LATENCY, 2, cycles from addr/rd_en to pixel data valid (legal range 0..7)

Ports:
- clk_low, in, 1, pixel clock; the block's only clock
- reset, in, 1, asynchronous, active-high
- enable, in, 1, run/hold control
- base_addr, in, ADDR_W, frame base address; sampled only at frame boundaries
- counter_x, out, CNT_W, current horizontal position
- counter_y, out, CNT_W, current vertical position
- rd_en, out, 1, framebuffer read strobe (active region)
- addr, out, ADDR_W, framebuffer read address
- pix_de, out, 1, data enable, aligned to returned data
- pix_hsync, out, 1, aligned hsync
- pix_vsync, out, 1, aligned vsync
- frame_start, out, 1, one-cycle pulse aligned with the first active pixel of each frame
- line_start, out, 1, one-cycle pulse aligned with the first active pixel of each active line

## Operation
- **Counters.** counter_x wraps H_TOT_PIXEL-1 → 0. counter_y increments on an x wrap and wraps V_TOT_PIXEL-1 → 0.
- **enable = 0.** At the next edge, counters load (0,0); rd_en = 0 and the delay line keeps shifting, so it drains within RD_LATENCY cycles.
- **base_addr sampling.** frame_base is loaded from base_addr on the cycle the counters wrap (H_TOT-1, V_TOT-1) → (0,0), and on any edge where enable = 0. Changes to base_addr mid-frame have no effect until the next frame.
- **Stage-0 decode.** Registered from the current counter values:
  - rd_en = (x < H_PIXEL) && (y < V_PIXEL)
  - hs = (x ≥ H_PIXEL+H_FRONT_PORCH) && (x < H_PIXEL+H_FRONT_PORCH+H_SYNC)
  - vs = (y ≥ V_PIXEL+V_FRONT_PORCH) && (y < V_PIXEL+V_FRONT_PORCH+V_SYNC); vs changes only at x = 0
  - fs = rd_en at (0,0)
  - ls = rd_en at x = 0
- **Address generation.** Incremental only; no multiplier.
  - line_base reloads to frame_base at frame wrap.
  - line_base += LINE_STRIDE at the end of each active line (x = H_TOT-1, y < V_PIXEL).
  - addr = line_base + x, registered. addr is held at its last value while rd_en = 0.
  - Arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- **Alignment.** Stage-0 signals hs, vs, rd_en, fs and ls pass through an RD_LATENCY-deep shift register. They emerge as pix_hsync, pix_vsync, pix_de, frame_start and line_start. Sync outputs are XOR-ed for SYNC_POL at the output.
- **Elaboration checks.** The following conditions cause a fatal error at elaboration:
  - H_PIXEL+H_FRONT_PORCH+H_SYNC > H_TOT_PIXEL (analogous check for V)
  - LINE_STRIDE < H_PIXEL
  - RD_LATENCY > 7
  - H_TOT_PIXEL or V_TOT_PIXEL ≥ 2^CNT_W

## Timing
- **Reset values.** Counters 0, frame_base 0, line_base 0, addr 0, rd_en 0, all delay stages 0, pix_de/frame_start/line_start 0.
- **Sync levels during reset.** pix_hsync and pix_vsync sit at their inactive level, i.e. !SYNC_POL.
- **Start-up.** On the first edge after reset release with enable = 1: rd_en = 1, addr = frame_base, counters advance to (1,0).
- **Latency.** rd_en/addr lag the counter value by 1 cycle. pix_* lags rd_en by exactly RD_LATENCY cycles; with RD_LATENCY = 0 they equal the stage-0 signals.
- **Reset mid-frame.** Everything returns to reset values asynchronously. Operation restarts at (0,0) with no partial line emitted.
- **Enable dropped mid-line.** rd_en falls at the next edge. In-flight stages still emerge, so pix_de shows the truncated line.

## Structure
- Shared package hdmi_video_pkg holds:
  - the 640x480@60 default timing constants
  - a helper function for the minimum legal CNT_W
- One sub-module, hdmi_delay_line, parametrised in WIDTH and DEPTH: a register chain that is a wire at DEPTH = 0. It is instantiated once with WIDTH = 5.

## Test plan
All scenarios use a small configuration: H_PIXEL=4, HFP=1, H_SYNC=2, H_TOT=9, V_PIXEL=3, VFP=1, V_SYNC=1, V_TOT=6, STRIDE=8, RD_LATENCY=2, SYNC_POL=1, base_addr=100.
- **Address sequence.** Run 1 frame → addr sequence 100–103, 108–111, 116–119 with rd_en high 12 cycles, 4 per line. The frame period is 54 cycles.
- **Sync placement and alignment.**
  - pix_hsync is high for 2 cycles, starting 7 cycles after the rd_en rise of the same line (x = 5 plus the 2-cycle delay).
  - pix_vsync is high for 9 cycles, covering line y = 4.
  - pix_de rises exactly 2 cycles after rd_en.
- **Pulses.** frame_start pulses once per frame, coincident with the first pix_de. line_start pulses 3 times per frame.
- **Base-address double buffering.** Change base_addr to 500 mid-frame → the current frame completes with base 100; the next frame starts at addr 500.
- **Enable / sync polarity.** Drop enable at x = 2 of line 1 → rd_en falls at the next edge; pix_de drains after 2 cycles. Raise enable → restart at (0,0) with addr = base_addr. With SYNC_POL=0, the sync outputs are inverted and idle high.
- **Reset mid-frame.** Assert reset mid-frame → all outputs reach reset values immediately, without a clock edge.

Source files
------------

// File: rtl/hdmi_video_pkg.sv
// Shared timing defaults and helpers for the HDMI video timing generator.
package hdmi_video_pkg;

  localparam int DEF_H_PIXEL       = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC        = 96;
  localparam int DEF_H_TOT_PIXEL   = 800;
  localparam int DEF_V_PIXEL       = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC        = 2;
  localparam int DEF_V_TOT_PIXEL   = 525;
  localparam int DEF_CNT_W         = 11;
  localparam int DEF_ADDR_W        = 21;
  localparam int DEF_LINE_STRIDE   = 640;
  localparam int DEF_RD_LATENCY    = 2;

  // Stage-0 decode bundle carried through the read-latency delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic ls;
  } stage0_t;

  localparam int STAGE0_W = $bits(stage0_t);

  // Smallest counter width able to hold the largest total count.
  function automatic int min_cnt_w(input int h_tot, input int v_tot);
    int m;
    m = (h_tot > v_tot) ? h_tot : v_tot;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hdmi_video_timing_gen_if.sv
// Control and pixel-side signal bundle of the video timing generator.
interface hdmi_video_timing_gen_if
  import hdmi_video_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              enable;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  counter_x;
  logic [CNT_W-1:0]  counter_y;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic              pix_de;
  logic              pix_hsync;
  logic              pix_vsync;
  logic              frame_start;
  logic              line_start;

  modport master (
    input  enable, base_addr,
    output counter_x, counter_y, rd_en, addr,
           pix_de, pix_hsync, pix_vsync, frame_start, line_start
  );

  modport slave (
    output enable, base_addr,
    input  counter_x, counter_y, rd_en, addr,
           pix_de, pix_hsync, pix_vsync, frame_start, line_start
  );
endinterface

// File: rtl/hdmi_delay_line.sv
// Fixed-depth register chain; collapses to a plain wire at DEPTH = 0.
module hdmi_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_regs
    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q_o = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// Video timing counters, sync/DE decode and double-buffered framebuffer
// read addressing, with pixel-side outputs aligned to the read latency.
module hdmi_video_timing_gen
  import hdmi_video_pkg::*;
#(
  parameter int H_PIXEL       = DEF_H_PIXEL,
  parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int H_SYNC        = DEF_H_SYNC,
  parameter int H_TOT_PIXEL   = DEF_H_TOT_PIXEL,
  parameter int V_PIXEL       = DEF_V_PIXEL,
  parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int V_SYNC        = DEF_V_SYNC,
  parameter int V_TOT_PIXEL   = DEF_V_TOT_PIXEL,
  parameter bit SYNC_POL      = 1'b1,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int LINE_STRIDE   = DEF_LINE_STRIDE,
  parameter int RD_LATENCY    = DEF_RD_LATENCY
) (
  input  logic                     clk_low,
  input  logic                     reset,
  hdmi_video_timing_gen_if.master  vif
);

  localparam int HS_START = H_PIXEL + H_FRONT_PORCH;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_PIXEL + V_FRONT_PORCH;
  localparam int VS_END   = VS_START + V_SYNC;

  if (HS_END > H_TOT_PIXEL) begin : g_bad_h
    $fatal(1, "horizontal active+porch+sync exceeds H_TOT_PIXEL");
  end
  if (VS_END > V_TOT_PIXEL) begin : g_bad_v
    $fatal(1, "vertical active+porch+sync exceeds V_TOT_PIXEL");
  end
  if (LINE_STRIDE < H_PIXEL) begin : g_bad_stride
    $fatal(1, "LINE_STRIDE smaller than H_PIXEL");
  end
  if (RD_LATENCY > 7) begin : g_bad_lat
    $fatal(1, "RD_LATENCY above 7");
  end
  if (CNT_W < min_cnt_w(H_TOT_PIXEL, V_TOT_PIXEL)) begin : g_bad_cnt_w
    $fatal(1, "CNT_W too narrow for the total counts");
  end

  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] frame_base_q, frame_base_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  stage0_t           s0_q, s0_d, pix_s;
  logic              x_last, y_last;

  assign x_last = (x_q == CNT_W'(H_TOT_PIXEL - 1));
  assign y_last = (y_q == CNT_W'(V_TOT_PIXEL - 1));

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    frame_base_d = frame_base_q;
    line_base_d  = line_base_q;
    addr_d       = addr_q;
    s0_d         = '0;
    if (!vif.enable) begin
      x_d          = '0;
      y_d          = '0;
      frame_base_d = vif.base_addr;
      line_base_d  = frame_base_d;
    end else begin
      s0_d.de = (x_q < CNT_W'(H_PIXEL)) && (y_q < CNT_W'(V_PIXEL));
      s0_d.hs = (x_q >= CNT_W'(HS_START)) && (x_q < CNT_W'(HS_END));
      s0_d.vs = (y_q >= CNT_W'(VS_START)) && (y_q < CNT_W'(VS_END));
      s0_d.fs = s0_d.de && (x_q == '0) && (y_q == '0);
      s0_d.ls = s0_d.de && (x_q == '0);
      // Address holds its last value outside the active region.
      if (s0_d.de) addr_d = line_base_q + ADDR_W'(x_q);
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d          = '0;
          frame_base_d = vif.base_addr;
          line_base_d  = frame_base_d;
        end else begin
          y_d = y_q + 1'b1;
          if (y_q < CNT_W'(V_PIXEL)) line_base_d = line_base_q + ADDR_W'(LINE_STRIDE);
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_low or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      frame_base_q <= '0;
      line_base_q  <= '0;
      addr_q       <= '0;
      s0_q         <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      frame_base_q <= frame_base_d;
      line_base_q  <= line_base_d;
      addr_q       <= addr_d;
      s0_q         <= s0_d;
    end
  end

  hdmi_delay_line #(
    .WIDTH (STAGE0_W),
    .DEPTH (RD_LATENCY)
  ) u_align (
    .clk_i (clk_low),
    .rst_i (reset),
    .d_i   (s0_q),
    .q_o   (pix_s)
  );

  assign vif.counter_x   = x_q;
  assign vif.counter_y   = y_q;
  assign vif.rd_en       = s0_q.de;
  assign vif.addr        = addr_q;
  assign vif.pix_de      = pix_s.de;
  assign vif.pix_hsync   = pix_s.hs ^ ~SYNC_POL;
  assign vif.pix_vsync   = pix_s.vs ^ ~SYNC_POL;
  assign vif.frame_start = pix_s.fs;
  assign vif.line_start  = pix_s.ls;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Bench for hdmi_video_timing_gen on a 9x6 toy raster, both sync polarities.
module tb_hdmi_video_timing_gen;

  localparam int HP = 4, HFP = 1, HSW = 2, HT = 9;
  localparam int VP = 3, VFP = 1, VSW = 1, VT = 6;
  localparam int STRIDE = 8, LAT = 2;

  logic        clk, rst, en;
  logic [20:0] base;

  hdmi_video_timing_gen_if #(.CNT_W(11), .ADDR_W(21)) ifa ();
  hdmi_video_timing_gen_if #(.CNT_W(11), .ADDR_W(21)) ifb ();

  assign ifa.enable    = en;
  assign ifa.base_addr = base;
  assign ifb.enable    = en;
  assign ifb.base_addr = base;

  hdmi_video_timing_gen #(
    .H_PIXEL(HP), .H_FRONT_PORCH(HFP), .H_SYNC(HSW), .H_TOT_PIXEL(HT),
    .V_PIXEL(VP), .V_FRONT_PORCH(VFP), .V_SYNC(VSW), .V_TOT_PIXEL(VT),
    .SYNC_POL(1'b1), .CNT_W(11), .ADDR_W(21), .LINE_STRIDE(STRIDE), .RD_LATENCY(LAT)
  ) dut_a (.clk_low(clk), .reset(rst), .vif(ifa));

  hdmi_video_timing_gen #(
    .H_PIXEL(HP), .H_FRONT_PORCH(HFP), .H_SYNC(HSW), .H_TOT_PIXEL(HT),
    .V_PIXEL(VP), .V_FRONT_PORCH(VFP), .V_SYNC(VSW), .V_TOT_PIXEL(VT),
    .SYNC_POL(1'b0), .CNT_W(11), .ADDR_W(21), .LINE_STRIDE(STRIDE), .RD_LATENCY(LAT)
  ) dut_b (.clk_low(clk), .reset(rst), .vif(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: linear raster position plus per-frame base.
  int          m_pos;
  logic [20:0] m_fb, m_addr;
  logic [4:0]  mpipe [0:LAT];   // {hs, vs, de, fs, ls}, [0] = newest

  task automatic model_reset();
    m_pos = 0; m_fb = '0; m_addr = '0;
    for (int i = 0; i <= LAT; i++) mpipe[i] = '0;
  endtask

  task automatic model_edge();
    int x, y;
    logic [4:0] s;
    s = '0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!en) begin
      m_pos = 0;
      m_fb  = base;
    end else begin
      x = m_pos % HT;
      y = m_pos / HT;
      s[2] = (x < HP) && (y < VP);
      s[4] = (x >= HP + HFP) && (x < HP + HFP + HSW);
      s[3] = (y >= VP + VFP) && (y < VP + VFP + VSW);
      s[1] = s[2] && (x == 0) && (y == 0);
      s[0] = s[2] && (x == 0);
      if (s[2]) m_addr = m_fb + 21'(y * STRIDE + x);
      m_pos++;
      if (m_pos == HT * VT) begin
        m_pos = 0;
        m_fb  = base;
      end
    end
    for (int i = LAT; i > 0; i--) mpipe[i] = mpipe[i-1];
    mpipe[0] = s;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_model();
    logic [48:0] ga, gb, ea, eb;
    logic [4:0]  p;
    p  = mpipe[LAT];
    ea = {11'(m_pos % HT), 11'(m_pos / HT), mpipe[0][2], m_addr, p[4], p[3], p[2], p[1], p[0]};
    eb = {11'(m_pos % HT), 11'(m_pos / HT), mpipe[0][2], m_addr, ~p[4], ~p[3], p[2], p[1], p[0]};
    ga = {ifa.counter_x, ifa.counter_y, ifa.rd_en, ifa.addr, ifa.pix_hsync, ifa.pix_vsync,
          ifa.pix_de, ifa.frame_start, ifa.line_start};
    gb = {ifb.counter_x, ifb.counter_y, ifb.rd_en, ifb.addr, ifb.pix_hsync, ifb.pix_vsync,
          ifb.pix_de, ifb.frame_start, ifb.line_start};
    chk("model_pol1", 64'(ga), 64'(ea));
    chk("model_pol0", 64'(gb), 64'(eb));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt"},  {ifa.counter_x, ifa.counter_y}, 64'd0);
    chk({tag, "_rd"},   {ifa.rd_en, ifa.addr}, 64'd0);
    chk({tag, "_pix"},  {ifa.pix_de, ifa.frame_start, ifa.line_start, ifa.pix_hsync, ifa.pix_vsync}, 64'd0);
    chk({tag, "_syncb"}, {ifb.pix_hsync, ifb.pix_vsync}, 64'd3);
  endtask

  typedef struct {
    logic        en;
    logic [20:0] base;
    int          n;
    int          ex, ey;
    logic        erd;
    logic [20:0] eaddr;
    logic        ede, ehs, evs;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int fs_cnt, ls_cnt, de_cnt, rd_cnt;
    bit found;

    tbl[0] = '{1'b1, 21'd100,  1, 1, 0, 1'b1, 21'd100, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 21'd100,  2, 3, 0, 1'b1, 21'd102, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 21'd100,  2, 5, 0, 1'b0, 21'd103, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 21'd100,  4, 0, 1, 1'b0, 21'd103, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 21'd100,  1, 1, 1, 1'b1, 21'd108, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 21'd100,  3, 4, 1, 1'b1, 21'd111, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 21'd500, 20, 6, 3, 1'b0, 21'd119, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 21'd500,  7, 4, 4, 1'b0, 21'd119, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 21'd500, 14, 0, 0, 1'b0, 21'd119, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 21'd500,  1, 1, 0, 1'b1, 21'd500, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b0; base = 21'd100;
    model_reset();
    #23;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    step();   // disabled edge samples base_addr = 100

    for (int i = 0; i < 10; i++) begin
      en   = tbl[i].en;
      base = tbl[i].base;
      for (int k = 0; k < tbl[i].n; k++) step();
      chk($sformatf("vec%0d", i),
          {ifa.counter_x, ifa.counter_y, ifa.rd_en, ifa.addr, ifa.pix_de, ifa.pix_hsync, ifa.pix_vsync},
          {11'(tbl[i].ex), 11'(tbl[i].ey), tbl[i].erd, tbl[i].eaddr, tbl[i].ede, tbl[i].ehs, tbl[i].evs});
    end

    // One full frame of pulses and strobes.
    fs_cnt = 0; ls_cnt = 0; de_cnt = 0; rd_cnt = 0;
    for (int k = 0; k < HT * VT; k++) begin
      step();
      fs_cnt += int'(ifa.frame_start);
      ls_cnt += int'(ifa.line_start);
      de_cnt += int'(ifa.pix_de);
      rd_cnt += int'(ifa.rd_en);
    end
    chk("frame_start_count", 64'(fs_cnt), 64'd1);
    chk("line_start_count",  64'(ls_cnt), 64'd3);
    chk("pix_de_count",      64'(de_cnt), 64'd12);
    chk("rd_en_count",       64'(rd_cnt), 64'd12);

    // Drop enable at x = 2 of line 1, then restart with a new base.
    found = 0;
    for (int k = 0; k < 2 * HT * VT && !found; k++) begin
      if (m_pos == HT + 2) found = 1;
      else step();
    end
    chk("find_x2_y1", 64'(found), 64'd1);
    en = 1'b0;
    step();
    chk("drop_rd", {ifa.rd_en, ifa.pix_de}, 64'b01);
    base = 21'd300;
    step();
    chk("drain_1", 64'(ifa.pix_de), 64'd1);
    step();
    chk("drain_2", 64'(ifa.pix_de), 64'd0);
    chk("idle_sync_pol0", {ifb.pix_hsync, ifb.pix_vsync}, 64'd3);
    en = 1'b1;
    step();
    chk("restart", {ifa.counter_x, ifa.counter_y, ifa.rd_en, ifa.addr},
        {11'd1, 11'd0, 1'b1, 21'd300});

    // Asynchronous reset mid-frame.
    for (int k = 0; k < 20; k++) step();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    model_reset();
    step();
    rst = 1'b0;
    en  = 1'b0;
    base = 21'd100;
    step();

    // Randomised run, including near-wrap base addresses.
    for (int k = 0; k < 800; k++) begin
      en = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 39) == 0)
        base = ($urandom_range(0, 1) == 1) ? 21'h1FFFFA : 21'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
